// File: rtl/fir_out_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : fir_out_buffer_if
// Description : Bus bundle between the FIR output buffer and its neighbours:
//               sample capture from the filter, the show-ahead output
//               handshake, and the occupancy/status flags.
// Revision    : 1.0 - initial release
// ============================================================================
interface fir_out_buffer_if #(
    parameter int IN_W  = 19,
    parameter int OUT_W = 12,
    parameter int DEPTH = 8
);
    localparam int c_cnt_w = $clog2(DEPTH) + 1;

    logic               valid_in;
    logic [IN_W-1:0]    y_in;
    logic [OUT_W-1:0]   out_data;
    logic               out_valid;
    logic               out_ready;
    logic [c_cnt_w-1:0] count;
    logic               overflow;
    logic               sat;

    // Buffer side: takes samples and consumer ready, drives data and status.
    modport slave (
        input  valid_in, y_in, out_ready,
        output out_data, out_valid, count, overflow, sat
    );

    // Environment side: FIR source plus consumer.
    modport master (
        output valid_in, y_in, out_ready,
        input  out_data, out_valid, count, overflow, sat
    );
endinterface
`default_nettype wire

// File: rtl/fir_out_buffer.sv
`default_nettype none
// ============================================================================
// Module      : fir_out_buffer
// Description : Captures 19-bit FIR results, scales them by a right shift
//               (truncating, or round-half-up when FIR_OUT_ROUND_EN is
//               defined), saturates to OUT_W bits and queues them in a
//               show-ahead FIFO with a valid/ready output. Dropped samples
//               and clipped samples raise sticky flags.
// Config      : FIR_OUT_ROUND_EN - enables round-half-up scaling.
// Revision    : 1.0 - initial release
// ============================================================================
module fir_out_buffer #(
    parameter int IN_W  = 19,
    parameter int OUT_W = 12,
    parameter int SHIFT = 7,
    parameter int DEPTH = 8
) (
    input  wire logic          clk,
    input  wire logic          rst,
    fir_out_buffer_if.slave    bus
);
    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;

    localparam logic [c_cnt_w-1:0] c_full    = c_cnt_w'(DEPTH);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
    localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);
    // Largest representable output word, widened to the scaling width.
    localparam logic [IN_W:0]      c_max     = {{(IN_W+1-OUT_W){1'b0}}, {OUT_W{1'b1}}};
`ifdef FIR_OUT_ROUND_EN
    localparam logic [IN_W:0]      c_round   = {{IN_W{1'b0}}, 1'b1} << (SHIFT - 1);
`endif

    logic [OUT_W-1:0]   mem_q [DEPTH];
    logic [OUT_W-1:0]   mem_d [DEPTH];
    logic [c_ptr_w-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_ptr_w-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_cnt_w-1:0] count_q, count_d;
    logic               overflow_q, overflow_d;
    logic               sat_q, sat_d;

    logic [IN_W:0]      w_sum;
    logic [IN_W:0]      w_scaled;
    logic               w_clip;
    logic [OUT_W-1:0]   w_word;
    logic               w_full;
    logic               w_pop;
    logic               w_push;
    logic               w_drop;

    // Scale the incoming sample one bit wider than the input so a rounding
    // carry survives until the saturation compare.
    always_comb begin
`ifdef FIR_OUT_ROUND_EN
        w_sum    = {1'b0, bus.y_in} + c_round;
`else
        w_sum    = {1'b0, bus.y_in};
`endif
        w_scaled = w_sum >> SHIFT;
        w_clip   = (w_scaled > c_max);
        w_word   = w_clip ? {OUT_W{1'b1}} : w_scaled[OUT_W-1:0];
    end

    // Handshake decode: a full FIFO still accepts a sample when the head
    // word leaves in the same cycle.
    always_comb begin
        w_full = (count_q == c_full);
        w_pop  = (count_q != '0) && bus.out_ready;
        w_push = bus.valid_in && (!w_full || w_pop);
        w_drop = bus.valid_in && w_full && !w_pop;
    end

    // Next-state for storage, pointers, occupancy and sticky flags.
    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q | w_drop;
        sat_d      = sat_q | (bus.valid_in && w_clip);

        if (w_push) begin
            mem_d[wr_ptr_q] = w_word;
            wr_ptr_d        = wr_ptr_q + c_ptr_one;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + c_ptr_one;
        end
        unique case ({w_push, w_pop})
            2'b10:   count_d = count_q + c_cnt_one;
            2'b01:   count_d = count_q - c_cnt_one;
            default: count_d = count_q;
        endcase
    end

    // State registers; reset empties the FIFO at once, without a clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            sat_q      <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            sat_q      <= sat_d;
        end
    end

    // Show-ahead output: the head word is always presented.
    always_comb begin
        bus.out_data  = mem_q[rd_ptr_q];
        bus.out_valid = (count_q != '0);
        bus.count     = count_q;
        bus.overflow  = overflow_q;
        bus.sat       = sat_q;
    end
endmodule
`default_nettype wire

// File: doc/fir_out_buffer.md
# fir_out_buffer

Downstream stage of the FIR filter. Captures each 19-bit filter result on its one-cycle valid pulse, then scales it to a narrower output word by right shift, optional rounding and saturation. Buffers results in a small FIFO and presents them to the consumer over a valid/ready handshake. The FIR output has no backpressure, so this block absorbs bursts and flags any lost samples.

## Interface
Parameters:
- IN_W, 19, width of incoming filter result (unsigned)
- OUT_W, 12, width of output word (unsigned)
- SHIFT, 7, right-shift applied before saturation; 1 ≤ SHIFT < IN_W
- DEPTH, 8, FIFO entries; power of two, ≥ 2

Ports:
- clock  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- valid_in  in  1  one-cycle pulse from FIR, qualifies y_in
- y_in  in  IN_W  filter result
- out_data  out  OUT_W  head-of-FIFO word, meaningful only when out_valid=1
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  consumer accepts head word this cycle
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- overflow  out  1  sticky: a sample was dropped because the FIFO was full
- sat  out  1  sticky: a sample was clipped to the maximum value

## Operation
- Scaling is combinational on y_in and computed at IN_W+1 bits: s = y_in >> SHIFT (see Configuration for rounding).
- Saturation: if s > 2^OUT_W−1, the stored word is 2^OUT_W−1 and sat sets; otherwise the stored word is s[OUT_W-1:0].
- Push: valid_in=1 and the FIFO is not full, or valid_in=1, full, and a pop happens the same cycle. The scaled word is written at mem[wr_ptr] and wr_ptr increments modulo DEPTH.
- Drop: valid_in=1, full, and no pop this cycle. The word is discarded, overflow sets, and the pointers and count are unchanged. sat still updates for the dropped word.
- Pop: out_valid=1 and out_ready=1. rd_ptr increments modulo DEPTH.
- FIFO is show-ahead: out_data = mem[rd_ptr] whenever out_valid=1.
- count: +1 on push only, −1 on pop only, unchanged on push and pop together.
- out_valid = (count != 0). The full condition is count == DEPTH.
- out_ready while empty has no effect.
- overflow and sat are cleared only by reset.
- Reset values: out_valid=0, count=0, overflow=0, sat=0, pointers=0. out_data is don't-care while out_valid=0, but the bench must see no X on out_valid or count.
- Reset asserted mid-burst immediately empties the FIFO; buffered contents are lost. A valid_in arriving during reset is ignored.

## Timing
- Latency: a push at edge n gives out_valid=1 and valid out_data after edge n (visible in cycle n+1).
- Throughput: one push and one pop per cycle. Sustained FIR rate is far below this, so occupancy stays bounded when the consumer keeps out_ready high.
- Empty with a push in the same cycle: no pop that cycle; the word appears next cycle.
- Full with push and pop together: both happen, count stays DEPTH, and no overflow.
- Pointer wrap-around from DEPTH−1 to 0 is seamless. Ordering is strict FIFO.

## Configuration
- FIR_OUT_ROUND_EN defined: round-half-up, s = (y_in + 2^(SHIFT−1)) >> SHIFT, computed at IN_W+1 bits so the carry is kept before saturation.
- FIR_OUT_ROUND_EN undefined: truncation, s = y_in >> SHIFT.
- All other behaviour is identical in both builds.

## Test plan
- Reset then idle: out_valid=0, count=0, overflow=0, sat=0; a pulse of out_ready changes nothing.
- Single sample y_in=19'd1000, out_ready=0: next cycle out_valid=1, out_data=7 (truncate) or 8 (with FIR_OUT_ROUND_EN), count=1. Raising out_ready for one cycle gives count=0.
- Saturation with SHIFT overridden to 4: y_in=19'h7FFFF gives out_data=12'hFFF and sat=1. y_in=19'd64 gives out_data=4 and sat stays 1.
- Fill: 8 pushes with out_ready=0 give count=8. A 9th push is dropped, overflow=1, and the pops return the first 8 values in order.
- Full with push and pop in the same cycle: count stays 8, overflow stays 0, and the new word comes out last.
- Reset asserted with count=5: out_valid=0 and count=0 immediately, without waiting for a clock edge. After release, a new push is read back correctly from pointer 0.
